bitserial_mac_array: RTL and testbench



---
 rtl/bitserial_mac_array.sv | 273 +++++++++++++++++++++++++++
 tb/tb_bitserial_mac_array.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitserial_mac_array.sv
// bitserial_mac_array: LANES signed activations times runtime-truncated signed
// weights, one weight bit per cycle (LSB first). Lane products are summed and
// accumulated over a vector; the dot product leaves on a valid/ready port.
// Optional macro SATURATE_EN: saturating accumulation with a sticky ovf flag.
// Without it the accumulator wraps and ovf is tied to 0.
module bitserial_mac_array #(
  parameter int LANES = 4,
  parameter int AW    = 8,
  parameter int WW    = 8,
  parameter int ACCW  = 20,
  localparam int PW   = (WW > 1) ? $clog2(WW) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [LANES*AW-1:0]    act,
  input  logic [LANES*WW-1:0]    wgt,
  input  logic [PW-1:0]          prec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [ACCW-1:0] out_data,
  output logic                   ovf,
  output logic                   busy
);

  localparam int LW = AW + WW;
  localparam logic [PW-1:0] PMAX = PW'(WW - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_ACC   = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [LANES*AW-1:0]      r_act;
  logic [LANES*WW-1:0]      r_wgt;
  logic [PW-1:0]            r_pm1;
  logic                     r_last;
  logic [PW-1:0]            r_cnt;
  logic signed [LW-1:0]     r_part [LANES];
  logic signed [ACCW-1:0]   r_acc;
  logic signed [ACCW-1:0]   r_out_data;
  logic                     r_out_valid;

  logic [PW-1:0]            w_pm1;
  logic [WW-1:0]            w_lane_w   [LANES];
  logic signed [LW-1:0]     w_term     [LANES];
  logic signed [LW-1:0]     w_part_nxt [LANES];
  logic signed [ACCW-1:0]   w_sum;
  logic signed [ACCW-1:0]   w_nacc;

  // Sign-extend one lane activation to partial-product width.
  function automatic logic signed [LW-1:0] sext_act(input logic [AW-1:0] a);
    return {{WW{a[AW-1]}}, a};
  endfunction

  // Sign-extend one lane partial to accumulator width.
  function automatic logic signed [ACCW-1:0] sext_part(input logic [LW-1:0] p);
    return {{(ACCW-LW){p[LW-1]}}, p};
  endfunction

  // Clamp the requested precision to the widest supported weight.
  always_comb begin
    if (int'(prec) > WW - 1) begin
      w_pm1 = PMAX;
    end else begin
      w_pm1 = prec;
    end
  end

  // Per-lane shift-add step; the top weight bit carries negative weight.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_lane_w[i] = r_wgt[i*WW +: WW];
      w_term[i]   = sext_act(r_act[i*AW +: AW]) <<< r_cnt;
      if (!w_lane_w[i][r_cnt]) begin
        w_part_nxt[i] = r_part[i];
      end else if (r_cnt == r_pm1) begin
        w_part_nxt[i] = r_part[i] - w_term[i];
      end else begin
        w_part_nxt[i] = r_part[i] + w_term[i];
      end
    end
  end

  // Adder tree across lanes, sign-extended to accumulator width.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sum = w_sum + sext_part(r_part[i]);
    end
  end

`ifdef SATURATE_EN
  localparam logic [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

  logic signed [ACCW:0] w_nacc_wide;
  logic                 w_sat;
  logic                 r_sticky;
  logic                 r_ovf;

  // Accumulate with one guard bit and clip to the signed range on overflow.
  always_comb begin
    w_nacc_wide = {r_acc[ACCW-1], r_acc} + {w_sum[ACCW-1], w_sum};
    if (w_nacc_wide[ACCW] != w_nacc_wide[ACCW-1]) begin
      w_sat = 1'b1;
      if (w_nacc_wide[ACCW]) begin
        w_nacc = ACC_MIN;
      end else begin
        w_nacc = ACC_MAX;
      end
    end else begin
      w_sat  = 1'b0;
      w_nacc = w_nacc_wide[ACCW-1:0];
    end
  end

  // Sticky saturation flag for the running dot product; copied to ovf on result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sticky <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (clear) begin
      r_sticky <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (r_state == S_ACC) begin
      if (r_last) begin
        r_ovf    <= r_sticky | w_sat;
        r_sticky <= 1'b0;
      end else begin
        r_sticky <= r_sticky | w_sat;
      end
    end
  end

  assign ovf = r_ovf;
`else
  // Plain two's-complement wrapping accumulation.
  always_comb begin
    w_nacc = r_acc + w_sum;
  end

  assign ovf = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            w_state_nxt = S_SHIFT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_SHIFT: begin
          if (r_cnt == r_pm1) begin
            w_state_nxt = S_ACC;
          end else begin
            w_state_nxt = S_SHIFT;
          end
        end
        S_ACC: begin
          if (r_last) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Datapath: operand capture, bit-serial partials, accumulator and result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_act       <= '0;
      r_wgt       <= '0;
      r_pm1       <= '0;
      r_last      <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_part[i] <= '0;
      end
    end else if (clear) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_part[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_act  <= act;
            r_wgt  <= wgt;
            r_pm1  <= w_pm1;
            r_last <= in_last;
            r_cnt  <= '0;
            for (int i = 0; i < LANES; i++) begin
              r_part[i] <= '0;
            end
          end
        end
        S_SHIFT: begin
          for (int i = 0; i < LANES; i++) begin
            r_part[i] <= w_part_nxt[i];
          end
          if (r_cnt != r_pm1) begin
            r_cnt <= r_cnt + PW'(1);
          end
        end
        S_ACC: begin
          if (r_last) begin
            r_out_data  <= w_nacc;
            r_out_valid <= 1'b1;
            r_acc       <= '0;
          end else begin
            r_acc <= w_nacc;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_bitserial_mac_array.sv
// Directed bench for bitserial_mac_array: table of single-element dot
// products, then sequences for accumulation, backpressure, clear, overflow
// and asynchronous reset.
module tb_bitserial_mac_array;

  localparam int LANES = 4;
  localparam int AW    = 8;
  localparam int WW    = 8;
  localparam int ACCW  = 20;
  localparam int PW    = 3;

  logic                   clk;
  logic                   rstn;
  logic                   clear;
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_last;
  logic [LANES*AW-1:0]    act;
  logic [LANES*WW-1:0]    wgt;
  logic [PW-1:0]          prec;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [ACCW-1:0] out_data;
  logic                   ovf;
  logic                   busy;

  int n_checks = 0;
  int n_errors = 0;

  bitserial_mac_array #(.LANES(LANES), .AW(AW), .WW(WW), .ACCW(ACCW)) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .act(act), .wgt(wgt),
    .prec(prec), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .ovf(ovf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] w;
    logic [2:0]  p;
    longint      exp;
  } vec_t;

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Present one element, hold it through the accept edge, then scramble the
  // inputs so later changes must be ignored by the DUT.
  task automatic send(input logic [31:0] a, input logic [31:0] w,
                      input logic [2:0] p, input logic l);
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    act = a; wgt = w; prec = p; in_last = l; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    act = ~a; wgt = ~w; prec = ~p; in_last = ~l;
  endtask

  // Edges from acceptance until out_valid is seen.
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  // Edges from acceptance until in_ready returns.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!in_ready && cyc < 40);
    if (!in_ready) chk("in_ready_return_timeout", 0, 1);
  endtask

  // Take the result with out_ready for one edge.
  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("consume_out_valid", out_valid, 0);
    chk("consume_in_ready", in_ready, 1);
  endtask

  vec_t vt [7];
  int   cyc;
  longint exp_ovf_data;
  longint exp_ovf_flag;

  initial begin
    vt[0] = '{32'h03030303, 32'h05050505, 3'd7, 60};
    vt[1] = '{32'h00000080, 32'h00000080, 3'd7, 16384};
    vt[2] = '{32'h0000000A, 32'h000000F7, 3'd3, 70};
    vt[3] = '{32'h0000000A, 32'h0000000F, 3'd3, -10};
    vt[4] = '{32'h00000507, 32'h0000FE01, 3'd0, -7};
    vt[5] = '{32'hFF7F64FD, 32'hFF7FFE04, 3'd7, 15918};
    vt[6] = '{32'h02020202, 32'hF8F8F8F8, 3'd3, -64};

    rstn = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    act = '0; wgt = '0; prec = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);

    // Single-element dot products: value, latency, hold, release.
    for (int i = 0; i < 7; i++) begin
      send(vt[i].a, vt[i].w, vt[i].p, 1'b1);
      wait_out(cyc);
      chk($sformatf("vec%0d_latency", i), cyc, longint'(vt[i].p) + 2);
      chk($sformatf("vec%0d_data", i), out_data, vt[i].exp);
      chk($sformatf("vec%0d_busy", i), busy, 1);
      chk($sformatf("vec%0d_ovf", i), ovf, 0);
      consume();
    end

    // Accumulate over three elements, then backpressure for five cycles.
    send(32'h00000001, 32'h00000002, 3'd7, 1'b0);
    wait_ready(cyc);
    chk("acc_in_ready_return", cyc, 9);
    send(32'h00000001, 32'h00000003, 3'd7, 1'b0);
    send(32'h00000001, 32'h00000004, 3'd7, 1'b1);
    wait_out(cyc);
    chk("acc_data", out_data, 9);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_data", k), out_data, 9);
      chk($sformatf("bp%0d_valid", k), out_valid, 1);
      chk($sformatf("bp%0d_in_ready", k), in_ready, 0);
    end
    consume();
    chk("acc_busy_after", busy, 0);

    // Clear mid-SHIFT of element 2 discards element 1 as well.
    send(32'h00000005, 32'h00000001, 3'd7, 1'b0);
    send(32'h00000005, 32'h00000001, 3'd7, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("clr_pre_busy", busy, 1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_in_ready", in_ready, 1);
    chk("clr_out_valid", out_valid, 0);
    // An element offered together with clear is refused.
    in_valid = 1'b1; in_last = 1'b1; act = 32'h00000001; wgt = 32'h00000001;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_coincident_busy", busy, 0);
    send(32'h00000001, 32'h00000001, 3'd7, 1'b1);
    wait_out(cyc);
    chk("clr_after_data", out_data, 1);
    consume();

    // Nine maximal elements overflow the accumulator.
`ifdef SATURATE_EN
    exp_ovf_data = 524287;
    exp_ovf_flag = 1;
`else
    exp_ovf_data = -458752;
    exp_ovf_flag = 0;
`endif
    for (int k = 0; k < 9; k++) begin
      send(32'h80808080, 32'h80808080, 3'd7, (k == 8) ? 1'b1 : 1'b0);
    end
    wait_out(cyc);
    chk("ovf_data", out_data, exp_ovf_data);
    chk("ovf_flag", ovf, exp_ovf_flag);
    consume();
    send(32'h00000001, 32'h00000001, 3'd7, 1'b1);
    wait_out(cyc);
    chk("post_ovf_data", out_data, 1);
    chk("post_ovf_flag", ovf, 0);
    consume();

    // Asynchronous reset in the middle of SHIFT.
    send(32'h00000003, 32'h00000003, 3'd7, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("arst_pre_busy", busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 1);
    @(negedge clk);
    rstn = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("arst_no_result", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
